fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined DLX core, sitting directly upstream of the instruction decoder. It owns the program counter, issues word reads to the synchronous instruction memory and presents one instruction per cycle to the decoder's instruction input. It also handles hazard-unit stalls with a hold buffer and handles redirects from jumps resolved in ID and branches resolved in EX.

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : DLX instruction-fetch stage. Owns the program counter, issues
//               word reads to a synchronous instruction memory, presents one
//               instruction per cycle to the decoder, parks the displayed
//               instruction in a hold buffer during stalls and redirects on
//               ID jumps and EX taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic        i_read_enable,
  input  logic [31:0] i_data_read,
  input  logic        stall,
  input  logic        redirect_id,
  input  logic [31:0] target_id,
  input  logic        redirect_ex,
  input  logic [31:0] target_ex,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] c_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;          // next sequential fetch address
  logic [31:0] r_fetch_pc;    // address of the outstanding response
  logic        r_live;        // outstanding response has not been killed
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc4;
  logic        r_hold_valid;

  logic [31:0] w_fa;
  logic        w_issue;
  logic        w_kill;
  logic [31:0] w_disp_instr;
  logic [31:0] w_disp_pc4;
  logic        w_disp_valid;

  // Issue address: EX branch beats ID jump; an ID jump only counts when not stalled.
  always_comb begin
    w_fa = r_pc;
    if (redirect_ex) begin
      w_fa = {target_ex[31:2], 2'b00};
    end else if (redirect_id && !stall) begin
      w_fa = {target_id[31:2], 2'b00};
    end
  end

  // BOOT always fetches; otherwise fetch unless stalled, but an EX redirect overrides the stall.
  assign w_issue = (r_state == S_BOOT) || redirect_ex || !stall;
  assign w_kill  = redirect_ex && (r_state != S_BOOT);

  // Instruction that would be shown to the decoder, before any EX kill.
  always_comb begin
    w_disp_instr = NOP;
    w_disp_pc4   = 32'h0000_0000;
    w_disp_valid = 1'b0;
    case (r_state)
      S_RUN: begin
        if (r_live) begin
          w_disp_instr = i_data_read;
          w_disp_pc4   = r_fetch_pc + 32'd4;
          w_disp_valid = 1'b1;
        end
      end
      S_HOLD: begin
        w_disp_instr = r_hold_instr;
        w_disp_pc4   = r_hold_pc4;
        w_disp_valid = r_hold_valid;
      end
      default: begin
        w_disp_instr = NOP;
        w_disp_pc4   = 32'h0000_0000;
        w_disp_valid = 1'b0;
      end
    endcase
  end

  // Output drive: reset forces idle values immediately; an EX redirect kills the ID slot.
  always_comb begin
    i_read_enable = 1'b0;
    i_address     = c_RESET_PC_ALIGNED;
    instr_out     = NOP;
    pc_plus4_out  = 32'h0000_0000;
    instr_valid   = 1'b0;
    if (!reset) begin
      i_read_enable = w_issue;
      i_address     = w_fa;
      if (!w_kill) begin
        instr_out    = w_disp_instr;
        pc_plus4_out = w_disp_pc4;
        instr_valid  = w_disp_valid;
      end
    end
  end

  // Fetch control: advance the PC on every issue, park the shown instruction on a RUN stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_BOOT;
      r_pc         <= c_RESET_PC_ALIGNED;
      r_fetch_pc   <= c_RESET_PC_ALIGNED;
      r_live       <= 1'b0;
      r_hold_instr <= NOP;
      r_hold_pc4   <= 32'h0000_0000;
      r_hold_valid <= 1'b0;
    end else if (w_issue) begin
      // Covers BOOT, normal advance, leaving HOLD and EX redirects; any hold is spent.
      r_state      <= S_RUN;
      r_pc         <= w_fa + 32'd4;
      r_fetch_pc   <= w_fa;
      r_live       <= 1'b1;
      r_hold_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      // Stall without redirect: the memory word will not survive, so keep a copy.
      r_state      <= S_HOLD;
      r_hold_instr <= w_disp_instr;
      r_hold_pc4   <= w_disp_pc4;
      r_hold_valid <= w_disp_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Directed scenarios plus a
//               randomized run against a behavioural fetch-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Primary DUT (RESET_PC = 0)
  logic        reset;
  logic [31:0] i_address;
  logic        i_read_enable;
  logic [31:0] i_data_read;
  logic        stall, redirect_id, redirect_ex;
  logic [31:0] target_id, target_ex;
  logic [31:0] instr_out, pc_plus4_out;
  logic        instr_valid;

  // Wrap-around DUT (RESET_PC = 0xFFFF_FFF8)
  logic        reset2;
  logic [31:0] addr2;
  logic        ren2;
  logic [31:0] rdata2;
  logic        stall2, rid2, rex2;
  logic [31:0] tid2, tex2;
  logic [31:0] instr2, pc42;
  logic        valid2;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .i_address(i_address), .i_read_enable(i_read_enable),
    .i_data_read(i_data_read), .stall(stall), .redirect_id(redirect_id),
    .target_id(target_id), .redirect_ex(redirect_ex), .target_ex(target_ex),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(32'h0000_0000)) dut_wrap (
    .clk(clk), .reset(reset2), .i_address(addr2), .i_read_enable(ren2),
    .i_data_read(rdata2), .stall(stall2), .redirect_id(rid2),
    .target_id(tid2), .redirect_ex(rex2), .target_ex(tex2),
    .instr_out(instr2), .pc_plus4_out(pc42), .instr_valid(valid2)
  );

  // Memory image: word N at address 4N, except a marker word at address 8.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h2001_0005;
    return a >> 2;
  endfunction

  // Synchronous instruction memories
  always @(posedge clk) if (i_read_enable) i_data_read <= mem_word(i_address);
  always @(posedge clk) if (ren2) rdata2 <= mem_word(addr2);

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0;
    redirect_id = 1'b1; target_id = 32'h55; redirect_ex = 1'b1; target_ex = 32'h77;
    @(negedge clk); #1;
    n_checks++; if (i_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %h exp 0", i_read_enable); end
    n_checks++; if (i_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", i_address); end
    n_checks++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr_out); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", instr_valid); end
    n_checks++; if (pc_plus4_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 0", pc_plus4_out); end
    redirect_id = 1'b0; redirect_ex = 1'b0; target_id = 32'h0; target_ex = 32'h0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) reset = 1'b0;
      #1;
      n_checks++; if (i_read_enable !== 1'b1) begin n_fail++; $display("FAIL seq_ren[%0d] got %h exp 1", k, i_read_enable); end
      n_checks++; if (i_address !== 32'(4*k)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h exp %h", k, i_address, 32'(4*k)); end
      if (k == 0) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %h exp 0", instr_valid); end
      end else begin
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %h exp 1", k, instr_valid); end
        n_checks++; if (instr_out !== mem_word(32'(4*(k-1)))) begin n_fail++; $display("FAIL seq_instr[%0d] got %h exp %h", k, instr_out, mem_word(32'(4*(k-1)))); end
        n_checks++; if (pc_plus4_out !== 32'(4*k)) begin n_fail++; $display("FAIL seq_pc4[%0d] got %h exp %h", k, pc_plus4_out, 32'(4*k)); end
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); stall = 1'b1; #1;
      n_checks++; if (i_read_enable !== 1'b0) begin n_fail++; $display("FAIL stall_ren[%0d] got %h exp 0", c, i_read_enable); end
      n_checks++; if (instr_out !== 32'h2001_0005) begin n_fail++; $display("FAIL stall_instr[%0d] got %h exp 20010005", c, instr_out); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %h exp 1", c, instr_valid); end
      n_checks++; if (pc_plus4_out !== 32'hC) begin n_fail++; $display("FAIL stall_pc4[%0d] got %h exp c", c, pc_plus4_out); end
    end
    @(negedge clk); stall = 1'b0; #1;
    n_checks++; if (i_read_enable !== 1'b1 || i_address !== 32'hC) begin n_fail++; $display("FAIL unstall_fetch got en=%h addr=%h exp en=1 addr=c", i_read_enable, i_address); end
    n_checks++; if (instr_out !== 32'h2001_0005) begin n_fail++; $display("FAIL unstall_instr got %h exp 20010005", instr_out); end
    @(negedge clk); #1;
    n_checks++; if (instr_out !== mem_word(32'hC) || pc_plus4_out !== 32'h10) begin n_fail++; $display("FAIL after_stall got instr=%h pc4=%h exp %h/10", instr_out, pc_plus4_out, mem_word(32'hC)); end
    n_checks++; if (i_address !== 32'h10) begin n_fail++; $display("FAIL after_stall_addr got %h exp 10", i_address); end
  endtask

  task automatic test_redirect_id();
    @(negedge clk); redirect_id = 1'b1; target_id = 32'h100; #1;
    n_checks++; if (i_address !== 32'h100 || i_read_enable !== 1'b1) begin n_fail++; $display("FAIL rid_addr got %h en=%h exp 100", i_address, i_read_enable); end
    n_checks++; if (instr_out !== mem_word(32'h10) || instr_valid !== 1'b1) begin n_fail++; $display("FAIL rid_jump_shown got %h v=%h exp %h", instr_out, instr_valid, mem_word(32'h10)); end
    @(negedge clk); redirect_id = 1'b0; #1;
    n_checks++; if (instr_out !== mem_word(32'h100) || pc_plus4_out !== 32'h104) begin n_fail++; $display("FAIL rid_target got %h pc4=%h exp %h/104", instr_out, pc_plus4_out, mem_word(32'h100)); end
    n_checks++; if (i_address !== 32'h104) begin n_fail++; $display("FAIL rid_next_addr got %h exp 104", i_address); end
  endtask

  task automatic test_redirect_ex_stall();
    @(negedge clk); stall = 1'b1; #1;
    n_checks++; if (i_read_enable !== 1'b0) begin n_fail++; $display("FAIL rex_pre_hold_ren got %h exp 0", i_read_enable); end
    @(negedge clk); redirect_ex = 1'b1; target_ex = 32'h40; redirect_id = 1'b1; target_id = 32'h200; #1;
    n_checks++; if (instr_out !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rex_kill got %h v=%h exp 0/0", instr_out, instr_valid); end
    n_checks++; if (i_address !== 32'h40 || i_read_enable !== 1'b1) begin n_fail++; $display("FAIL rex_addr got %h en=%h exp 40/1", i_address, i_read_enable); end
    @(negedge clk); redirect_ex = 1'b0; redirect_id = 1'b0; stall = 1'b0; #1;
    n_checks++; if (instr_out !== mem_word(32'h40) || instr_valid !== 1'b1 || pc_plus4_out !== 32'h44) begin n_fail++; $display("FAIL rex_target got %h v=%h pc4=%h exp %h/1/44", instr_out, instr_valid, pc_plus4_out, mem_word(32'h40)); end
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk); stall = 1'b1; #1;
    n_checks++; if (instr_out !== mem_word(32'h44)) begin n_fail++; $display("FAIL rih_shown got %h exp %h", instr_out, mem_word(32'h44)); end
    @(negedge clk); #1;
    #1 reset = 1'b1; #1;
    n_checks++; if (i_read_enable !== 1'b0 || i_address !== 32'h0) begin n_fail++; $display("FAIL rih_mem got en=%h addr=%h exp 0/0", i_read_enable, i_address); end
    n_checks++; if (instr_out !== 32'h0 || instr_valid !== 1'b0 || pc_plus4_out !== 32'h0) begin n_fail++; $display("FAIL rih_out got %h v=%h pc4=%h exp 0", instr_out, instr_valid, pc_plus4_out); end
    @(negedge clk); reset = 1'b0; stall = 1'b0; #1;
    n_checks++; if (i_read_enable !== 1'b1 || i_address !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rih_boot got en=%h addr=%h v=%h exp 1/0/0", i_read_enable, i_address, instr_valid); end
    @(negedge clk); #1;
    n_checks++; if (instr_out !== mem_word(32'h0) || instr_valid !== 1'b1 || pc_plus4_out !== 32'h4) begin n_fail++; $display("FAIL rih_first got %h v=%h pc4=%h exp %h/1/4", instr_out, instr_valid, pc_plus4_out, mem_word(32'h0)); end
  endtask

  task automatic test_wrap();
    @(negedge clk); reset2 = 1'b0; #1;
    n_checks++; if (addr2 !== 32'hFFFF_FFF8 || ren2 !== 1'b1) begin n_fail++; $display("FAIL wrap_a0 got %h en=%h exp fffffff8", addr2, ren2); end
    @(negedge clk); #1;
    n_checks++; if (addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a1 got %h exp fffffffc", addr2); end
    n_checks++; if (instr2 !== mem_word(32'hFFFF_FFF8) || pc42 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_d0 got %h pc4=%h exp %h/fffffffc", instr2, pc42, mem_word(32'hFFFF_FFF8)); end
    @(negedge clk); #1;
    n_checks++; if (addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_a2 got %h exp 0", addr2); end
    n_checks++; if (instr2 !== mem_word(32'hFFFF_FFFC) || pc42 !== 32'h0) begin n_fail++; $display("FAIL wrap_d1 got %h pc4=%h exp %h/0", instr2, pc42, mem_word(32'hFFFF_FFFC)); end
    @(negedge clk); rid2 = 1'b1; tid2 = 32'h103; #1;
    n_checks++; if (addr2 !== 32'h100) begin n_fail++; $display("FAIL wrap_align got %h exp 100", addr2); end
    @(negedge clk); rid2 = 1'b0; #1;
    n_checks++; if (instr2 !== mem_word(32'h100) || pc42 !== 32'h104) begin n_fail++; $display("FAIL wrap_tgt got %h pc4=%h exp %h/104", instr2, pc42, mem_word(32'h100)); end
  endtask

  // Randomized run against a fetch-stream model: which address is shown, and is a parked copy shown instead.
  task automatic test_random();
    bit          m_boot, m_held, h_valid, e_ren, e_valid, sv;
    logic [31:0] m_pc, m_shown_addr, h_word, h_pc4, fa, e_instr, sw, sp;
    @(negedge clk); reset = 1'b1; stall = 1'b0; redirect_id = 1'b0; redirect_ex = 1'b0;
    @(negedge clk); reset = 1'b0;
    m_boot = 1'b1; m_held = 1'b0; h_valid = 1'b0; m_pc = 32'h0; m_shown_addr = 32'h0;
    h_word = 32'h0; h_pc4 = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect_id = ($urandom_range(0, 9) == 0);
      redirect_ex = ($urandom_range(0, 11) == 0);
      target_id   = $urandom;
      target_ex   = $urandom;
      #1;
      if (redirect_ex) fa = target_ex & 32'hFFFF_FFFC;
      else if (redirect_id && !stall) fa = target_id & 32'hFFFF_FFFC;
      else fa = m_pc;
      sw = 32'h0; sp = 32'h0; sv = 1'b0;
      if (m_boot) begin
        e_ren = 1'b1; e_valid = 1'b0; e_instr = 32'h0;
      end else begin
        e_ren = redirect_ex || !stall;
        if (m_held) begin sw = h_word; sp = h_pc4; sv = h_valid; end
        else begin sw = mem_word(m_shown_addr); sp = m_shown_addr + 32'd4; sv = 1'b1; end
        e_valid = redirect_ex ? 1'b0 : sv;
        e_instr = redirect_ex ? 32'h0 : sw;
      end
      n_checks++; if (i_read_enable !== e_ren) begin n_fail++; $display("FAIL rnd_ren[%0d] got %h exp %h", cyc, i_read_enable, e_ren); end
      if (e_ren) begin
        n_checks++; if (i_address !== fa) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h exp %h", cyc, i_address, fa); end
      end
      n_checks++; if (instr_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %h exp %h", cyc, instr_valid, e_valid); end
      n_checks++; if (instr_out !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h exp %h", cyc, instr_out, e_instr); end
      if (e_valid) begin
        n_checks++; if (pc_plus4_out !== sp) begin n_fail++; $display("FAIL rnd_pc4[%0d] got %h exp %h", cyc, pc_plus4_out, sp); end
      end
      if (m_boot || e_ren) begin
        m_shown_addr = fa; m_pc = fa + 32'd4; m_boot = 1'b0; m_held = 1'b0;
      end else if (!m_held) begin
        m_held = 1'b1; h_word = sw; h_pc4 = sp; h_valid = sv;
      end
      @(negedge clk);
    end
    stall = 1'b0; redirect_id = 1'b0; redirect_ex = 1'b0;
  endtask

  initial begin
    reset2 = 1'b1; stall2 = 1'b0; rid2 = 1'b0; rex2 = 1'b0; tid2 = 32'h0; tex2 = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_id();
    test_redirect_ex_stall();
    test_reset_in_hold();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
